// File: rtl/rv32_pkg.sv
// Shared RV32 core types: datapath widths and the writeback request payload.
package rv32_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the W stage / multi-cycle units / decode and the write arbiter.
interface regfile_write_arbiter_if import rv32_pkg::*; #(
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              pipe_we;
  logic [REG_AW-1:0] pipe_rd;
  logic [XLEN-1:0]   pipe_data;
  logic              mc_valid;
  logic              mc_ready;
  logic [REG_AW-1:0] mc_rd;
  logic [XLEN-1:0]   mc_data;
  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_data;
  logic [REG_AW-1:0] q_a1;
  logic [REG_AW-1:0] q_a2;
  logic              busy1;
  logic              busy2;
  logic              stall_req;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data, q_a1, q_a2,
    input  mc_ready, rf_we, rf_rd, rf_data, busy1, busy2, stall_req, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data, q_a1, q_a2,
    output mc_ready, rf_we, rf_rd, rf_data, busy1, busy2, stall_req, fifo_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests with per-entry valid bits and
// destination-match vectors used by the decode scoreboard.
module wb_fifo import rv32_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  input  logic [REG_AW-1:0]      q_a1,
  input  logic [REG_AW-1:0]      q_a2,
  output logic [DEPTH-1:0]       match1,
  output logic [DEPTH-1:0]       match2
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  wb_req_t           mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers, occupancy and valid bits; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      valid  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_pop)  valid[rd_ptr] <= 1'b0;
      if (do_push) valid[wr_ptr] <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage; qualified by the valid bits so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Per-entry destination compare against both decode source addresses.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match1[i] = valid[i] && (mem[i].rd == q_a1);
      match2[i] = valid[i] && (mem[i].rd == q_a2);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writeback with buffered long-latency results onto the single
// register-file write port, and reports pending destinations to decode.
module regfile_write_arbiter import rv32_pkg::*; #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_write_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SW    = $clog2(STARVE_MAX + 1);

  wb_req_t           push_data;
  wb_req_t           head;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic [DEPTH-1:0]  match1;
  logic [DEPTH-1:0]  match2;
  logic              pipe_valid;
  logic              mc_ready;
  logic              mc_hs;
  logic              push;
  logic              pop;
  logic [SW-1:0]     starve_cnt;
  logic [SW-1:0]     starve_nxt;

  assign pipe_valid = bus.pipe_we && (bus.pipe_rd != '0);
  assign mc_ready   = rst_n && !full;
  assign mc_hs      = bus.mc_valid && mc_ready;
  assign push       = mc_hs && (bus.mc_rd != '0);
  assign pop        = !pipe_valid && !empty;
  assign push_data  = '{rd: bus.mc_rd, data: bus.mc_data};

  assign bus.mc_ready   = mc_ready;
  assign bus.fifo_count = count;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .q_a1      (bus.q_a1),
    .q_a2      (bus.q_a2),
    .match1    (match1),
    .match2    (match2)
  );

  // Scoreboard lookup: queued entries plus a result being accepted this cycle.
  always_comb begin
    bus.busy1 = rst_n && (bus.q_a1 != '0) &&
                ((|match1) || (mc_hs && (bus.mc_rd == bus.q_a1)));
    bus.busy2 = rst_n && (bus.q_a2 != '0) &&
                ((|match2) || (mc_hs && (bus.mc_rd == bus.q_a2)));
  end

  // Write port register: pipeline first, then FIFO head, else idle with held data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rf_we   <= 1'b0;
      bus.rf_rd   <= '0;
      bus.rf_data <= '0;
    end else if (pipe_valid) begin
      bus.rf_we   <= 1'b1;
      bus.rf_rd   <= bus.pipe_rd;
      bus.rf_data <= bus.pipe_data;
    end else if (!empty) begin
      bus.rf_we   <= 1'b1;
      bus.rf_rd   <= head.rd;
      bus.rf_data <= head.data;
    end else begin
      bus.rf_we   <= 1'b0;
    end
  end

  // Count consecutive pipeline wins over a waiting FIFO head.
  always_comb begin
    starve_nxt = '0;
    if (pipe_valid && !empty) starve_nxt = starve_cnt + SW'(1);
  end

  // Pulse stall_req once the limit is reached, then restart the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt    <= '0;
      bus.stall_req <= 1'b0;
    end else if (starve_nxt == SW'(STARVE_MAX)) begin
      starve_cnt    <= '0;
      bus.stall_req <= 1'b1;
    end else begin
      starve_cnt    <= starve_nxt;
      bus.stall_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus hand-written
// reset, pipeline, starvation and reset-with-pending sequences.
module tb_regfile_write_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pend_cnt [32];

  regfile_write_arbiter_if #(.DEPTH(4)) bus ();

  regfile_write_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic [4:0]  qa1;
    logic [4:0]  qa2;
    logic        e_ready;
    logic        e_b1;
    logic        e_b2;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_stall;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(logic pwe, logic [4:0] prd, logic [31:0] pdata,
                              logic mv, logic [4:0] mrd, logic [31:0] mdata,
                              logic [4:0] qa1, logic [4:0] qa2,
                              logic e_ready, logic e_b1, logic e_b2,
                              logic e_we, logic [4:0] e_rd, logic [31:0] e_data,
                              logic [2:0] e_cnt, logic e_stall);
    vec_t v;
    v.pwe = pwe; v.prd = prd; v.pdata = pdata;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.qa1 = qa1; v.qa2 = qa2;
    v.e_ready = e_ready; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_we = e_we; v.e_rd = e_rd; v.e_data = e_data;
    v.e_cnt = e_cnt; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                       input logic [4:0] qa1, input logic [4:0] qa2);
    bus.pipe_we = pwe; bus.pipe_rd = prd; bus.pipe_data = pdata;
    bus.mc_valid = mv; bus.mc_rd = mrd; bus.mc_data = mdata;
    bus.q_a1 = qa1; bus.q_a2 = qa2;
  endtask

  // Ordering check: a pipeline write must never target a destination still queued.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) pend_cnt[r] = 0;
    end else begin
      if (bus.rf_we && pend_cnt[bus.rf_rd] > 0) pend_cnt[bus.rf_rd]--;
      if (bus.pipe_we && bus.pipe_rd != 5'd0) begin
        n_checks++;
        if (pend_cnt[bus.pipe_rd] != 0) begin
          n_fail++;
          $display("FAIL waw: pipeline rd=%0d while %0d queued", bus.pipe_rd,
                   pend_cnt[bus.pipe_rd]);
        end
      end
      if (bus.mc_valid && bus.mc_ready && bus.mc_rd != 5'd0) pend_cnt[bus.mc_rd]++;
    end
  end

  initial begin
    // fill and drain, pipeline rd 10..14 keeps winning while the FIFO fills
    vecs[0]  = mk(1, 10, 32'hA0, 1, 1, 32'h11, 1, 0,  1, 1, 0,  1, 10, 32'hA0, 1, 0);
    vecs[1]  = mk(1, 11, 32'hA1, 1, 2, 32'h22, 1, 2,  1, 1, 1,  1, 11, 32'hA1, 2, 0);
    vecs[2]  = mk(1, 12, 32'hA2, 1, 3, 32'h33, 3, 4,  1, 1, 0,  1, 12, 32'hA2, 3, 0);
    vecs[3]  = mk(1, 13, 32'hA3, 1, 4, 32'h44, 3, 0,  1, 1, 0,  1, 13, 32'hA3, 4, 0);
    vecs[4]  = mk(1, 14, 32'hA4, 1, 9, 32'h99, 3, 9,  0, 1, 0,  1, 14, 32'hA4, 4, 0);
    vecs[5]  = mk(0, 0,  32'h0,  0, 0, 32'h0,  1, 4,  0, 1, 1,  1, 1,  32'h11, 3, 0);
    vecs[6]  = mk(0, 0,  32'h0,  0, 0, 32'h0,  1, 0,  1, 0, 0,  1, 2,  32'h22, 2, 0);
    vecs[7]  = mk(0, 0,  32'h0,  0, 0, 32'h0,  3, 0,  1, 1, 0,  1, 3,  32'h33, 1, 0);
    vecs[8]  = mk(0, 0,  32'h0,  0, 0, 32'h0,  4, 3,  1, 1, 0,  1, 4,  32'h44, 0, 0);
    vecs[9]  = mk(0, 0,  32'h0,  0, 0, 32'h0,  4, 0,  1, 0, 0,  0, 4,  32'h44, 0, 0);
    // simultaneous enqueue/dequeue at count 2, then an rd=0 discard
    vecs[10] = mk(1, 15, 32'hF0, 1, 6, 32'h66, 6, 0,  1, 1, 0,  1, 15, 32'hF0, 1, 0);
    vecs[11] = mk(1, 16, 32'hF1, 1, 7, 32'h77, 6, 7,  1, 1, 1,  1, 16, 32'hF1, 2, 0);
    vecs[12] = mk(0, 0,  32'h0,  1, 8, 32'h88, 8, 6,  1, 1, 1,  1, 6,  32'h66, 2, 0);
    vecs[13] = mk(1, 17, 32'hF2, 1, 0, 32'hBAD, 7, 0, 1, 1, 0,  1, 17, 32'hF2, 2, 0);
    vecs[14] = mk(0, 0,  32'h0,  0, 0, 32'h0,  7, 8,  1, 1, 1,  1, 7,  32'h77, 1, 0);
    vecs[15] = mk(0, 0,  32'h0,  0, 0, 32'h0,  8, 0,  1, 1, 0,  1, 8,  32'h88, 0, 0);
    vecs[16] = mk(0, 0,  32'h0,  0, 0, 32'h0,  0, 0,  1, 0, 0,  0, 8,  32'h88, 0, 0);

    // reset held two cycles with every input active
    rst_n = 1'b0;
    drive(1, 5, 32'h1234_5678, 1, 3, 32'h3333, 3, 5);
    tick();
    tick();
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
    chk("rst_rf_data", bus.rf_data, 32'd0);
    chk("rst_mc_ready", 32'(bus.mc_ready), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_busy1", 32'(bus.busy1), 32'd0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    tick();
    chk("rel_mc_ready", 32'(bus.mc_ready), 32'd1);
    chk("rel_rf_we", 32'(bus.rf_we), 32'd0);

    // pipeline-only writes, rd=0 ignored
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 0);
    tick();
    chk("pipe_we", 32'(bus.rf_we), 32'd1);
    chk("pipe_rd", 32'(bus.rf_rd), 32'd5);
    chk("pipe_data", bus.rf_data, 32'hDEAD_BEEF);
    drive(1, 0, 32'h0BAD_0BAD, 0, 0, 32'h0, 0, 0);
    tick();
    chk("pipe_rd0_we", 32'(bus.rf_we), 32'd0);
    chk("pipe_rd0_hold", bus.rf_data, 32'hDEAD_BEEF);

    // table vectors: combinational outputs before the edge, registered after
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].pwe, vecs[i].prd, vecs[i].pdata, vecs[i].mv, vecs[i].mrd,
            vecs[i].mdata, vecs[i].qa1, vecs[i].qa2);
      #1;
      chk($sformatf("v%0d_mc_ready", i), 32'(bus.mc_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_busy1", i), 32'(bus.busy1), 32'(vecs[i].e_b1));
      chk($sformatf("v%0d_busy2", i), 32'(bus.busy2), 32'(vecs[i].e_b2));
      tick();
      chk($sformatf("v%0d_rf_we", i), 32'(bus.rf_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_rf_rd", i), 32'(bus.rf_rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_rf_data", i), bus.rf_data, vecs[i].e_data);
      chk($sformatf("v%0d_count", i), 32'(bus.fifo_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_stall", i), 32'(bus.stall_req), 32'(vecs[i].e_stall));
    end

    // starvation: rd=7 waits behind eight consecutive pipeline wins
    drive(1, 20, 32'h200, 1, 7, 32'h77, 0, 0);
    tick();
    chk("stv_count", 32'(bus.fifo_count), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 5'(21 + i), 32'(32'h210 + i), 0, 0, 32'h0, 0, 0);
      tick();
      chk($sformatf("stv_rd_%0d", i), 32'(bus.rf_rd), 32'(21 + i));
      chk($sformatf("stv_stall_%0d", i), 32'(bus.stall_req), (i == 7) ? 32'd1 : 32'd0);
    end
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    tick();
    chk("stv_drain_we", 32'(bus.rf_we), 32'd1);
    chk("stv_drain_rd", 32'(bus.rf_rd), 32'd7);
    chk("stv_drain_data", bus.rf_data, 32'h77);
    chk("stv_drain_stall", 32'(bus.stall_req), 32'd0);
    chk("stv_drain_count", 32'(bus.fifo_count), 32'd0);

    // reset with three results queued discards them
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(29 + i), 32'(32'h290 + i), 1, 5'(9 + i), 32'(32'h900 + i), 0, 0);
      tick();
    end
    chk("rq_count", 32'(bus.fifo_count), 32'd3);
    drive(0, 0, 32'h0, 0, 0, 32'h0, 9, 10);
    #1;
    chk("rq_busy1_pre", 32'(bus.busy1), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rq_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rq_rst_rf_rd", 32'(bus.rf_rd), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rq_post_we_%0d", i), 32'(bus.rf_we), 32'd0);
      chk($sformatf("rq_post_busy1_%0d", i), 32'(bus.busy1), 32'd0);
      chk($sformatf("rq_post_busy2_%0d", i), 32'(bus.busy2), 32'd0);
      chk($sformatf("rq_post_count_%0d", i), 32'(bus.fifo_count), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-side front end of the register file: merges the in-order pipeline writeback stream with results from long-latency units (divider, outstanding loads) onto the register file's single write port. Long-latency results are buffered in a small FIFO and drained in cycles where the pipeline does not write. The block also acts as a scoreboard: decode queries it to stall on pending destinations. It sits between the W stage / multi-cycle units and the register file's RegWriteW/RdW/ResultW inputs.

## Interface
- DEPTH, 4, FIFO entries for long-latency results; power of two, ≥2
- STARVE_MAX, 8, consecutive pipeline-won cycles with a non-empty FIFO before stall_req asserts
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- pipe_we  in  1  pipeline writeback request; cannot be back-pressured
- pipe_rd  in  5  pipeline destination
- pipe_data  in  32  pipeline result
- mc_valid  in  1  long-latency result valid
- mc_ready  out  1  FIFO can accept
- mc_rd  in  5  long-latency destination
- mc_data  in  32  long-latency result
- rf_we  out  1  to register file RegWriteW, registered
- rf_rd  out  5  to register file RdW, registered
- rf_data  out  32  to register file ResultW, registered
- q_a1, q_a2  in  5 each  decode source addresses
- busy1, busy2  out  1 each  source has a pending FIFO write
- stall_req  out  1  request a one-cycle pipeline bubble in W
- fifo_count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Pipeline request valid only when pipe_we=1 and pipe_rd≠0. A pipeline request with rd=0 is ignored.
- mc handshake occurs when mc_valid && mc_ready.
  - Handshake with mc_rd≠0: enqueue {rd, data} at the tail.
  - Handshake with mc_rd=0: consume the result and discard it; no enqueue.
- mc_ready = rst_n && (count<DEPTH), computed from the current count. No same-cycle dequeue credit.
- Arbitration each cycle, fixed priority:
  - Valid pipeline request wins.
  - Otherwise, if FIFO non-empty, the head wins and is dequeued the same edge.
  - Otherwise rf_we=0.
- Output register captures the winner: rf_we=1, rf_rd, rf_data. When idle: rf_we=0; rf_rd and rf_data hold their previous values.
- Enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- busy_n (n=1,2) is combinational:
  - 0 if q_an=0.
  - 1 if any valid FIFO entry has rd==q_an, or a handshake is in progress this cycle with mc_rd==q_an.
  - An entry being dequeued this cycle still counts as busy.
- Starvation counter:
  - Increments when FIFO non-empty and the pipeline wins.
  - Clears when the FIFO wins or the FIFO is empty.
  - stall_req=1 (registered) when counter==STARVE_MAX; the counter then clears.
  - The hazard unit guarantees pipe_we=0 in the following cycle, so the head drains.
- WAW ordering: decode stalls on busy, so the pipeline never writes an rd that is pending in the FIFO. The block does not check this; the bench asserts it.

## Timing
- Pipeline path: 1-cycle latency (request at edge t → rf_we high after edge t+1).
- mc path, empty FIFO, no pipeline traffic: handshake at edge t → rf_we after edge t+1.
- Reset (rst_n low at an edge) sets:
  - rf_we=0, rf_rd=0, rf_data=0
  - count=0, pointers=0, starvation counter=0
  - stall_req=0, busy1/busy2=0, mc_ready=0 while rst_n low
- Reset mid-operation discards FIFO contents; no write is issued for discarded entries.
- Full with mc_valid held: mc_ready stays 0 until the edge after a dequeue.

## Structure
- Shared package rv32_pkg:
  - XLEN=32 and REG_AW=5
  - typedef wb_req_t {logic [4:0] rd; logic [31:0] data;}
- Sub-module wb_fifo: synchronous FIFO of wb_req_t with per-entry valid bits. Exports a match vector for the busy compare.
- Arbiter, output register and starvation counter live in the top.

## Test plan
- Reset: rst_n=0 for 2 cycles with all inputs active → rf_we=0, rf_rd=0, rf_data=0, mc_ready=0, fifo_count=0; mc_ready=1 the cycle after release.
- Pipeline only: pipe_we=1, rd=5, data=0xDEADBEEF → next cycle rf_we=1, rf_rd=5, rf_data=0xDEADBEEF. With rd=0 → rf_we=0.
- Fill and drain: 4 mc handshakes (rd 1–4, data 0x11–0x44) with pipe_we=1 throughout → mc_ready=0 at count 4.
  - busy1=1 for q_a1=3.
  - After pipe_we drops, writes rd 1,2,3,4 on consecutive cycles in order.
- Simultaneous enqueue and dequeue at count=2 → count stays 2, order preserved. mc_rd=0 handshake → accepted, count unchanged.
- Starvation: FIFO holds rd=7, pipe_we=1 continuously → stall_req pulses after 8 pipeline wins. Forcing pipe_we=0 next cycle writes rd=7.
- Reset with 3 entries queued → no rf_we for those entries after release; busy1=busy2=0.
